// File: rtl/sdc_blk_ctl.sv
`default_nettype none
// ============================================================================
// Module   : sdc_blk_ctl
// Purpose  : SD card single-block read/write sequencer driving an SPI engine.
//            SDC_BYTE_ADDR_EN selects byte addressing for standard-capacity cards.
// Revision : 1.0 - initial release
// ============================================================================
module sdc_blk_ctl #(
    parameter int RESP_POLLS  = 16,
    parameter int TOKEN_POLLS = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        go,
    input  logic        wr,
    input  logic [31:0] lba,
    output logic        busy,
    output logic        done,
    output logic [2:0]  err,
    output logic [31:0] rd_word,
    output logic        rd_valid,
    input  logic [31:0] wr_word,
    output logic        wr_req,
    output logic        ss_n,
    output logic        spi_fast,
    output logic        spi_start,
    output logic [31:0] spi_dataTx,
    input  logic [31:0] spi_dataRx,
    input  logic        spi_rdy
);

    localparam logic [3:0] c_IDLE   = 4'd0;
    localparam logic [3:0] c_CMD    = 4'd1;
    localparam logic [3:0] c_R1     = 4'd2;
    localparam logic [3:0] c_TOKEN  = 4'd3;
    localparam logic [3:0] c_RDATA  = 4'd4;
    localparam logic [3:0] c_RCRC   = 4'd5;
    localparam logic [3:0] c_WGAP   = 4'd6;
    localparam logic [3:0] c_WTOKEN = 4'd7;
    localparam logic [3:0] c_WDATA  = 4'd8;
    localparam logic [3:0] c_WCRC   = 4'd9;
    localparam logic [3:0] c_WRESP  = 4'd10;
    localparam logic [3:0] c_WBUSY  = 4'd11;
    localparam logic [3:0] c_DESEL  = 4'd12;
    localparam logic [3:0] c_DONE   = 4'd13;

    localparam logic [1:0] c_P_LOAD   = 2'd0;
    localparam logic [1:0] c_P_ISSUE  = 2'd1;
    localparam logic [1:0] c_P_SETTLE = 2'd2;
    localparam logic [1:0] c_P_WAIT   = 2'd3;

    localparam logic [15:0] c_RESP_LIM  = 16'(RESP_POLLS);
    localparam logic [15:0] c_TOKEN_LIM = 16'(TOKEN_POLLS);

    logic [3:0]  r_state;
    logic [1:0]  r_phase;
    logic [15:0] r_cnt;
    logic [6:0]  r_wcnt;
    logic        r_wr;
    logic [31:0] r_lba;

    logic [31:0] w_arg;
    logic [7:0]  w_rx8;
    logic [15:0] w_cnt_nx;
    logic        w_xfer;
    logic [31:0] w_load_tx;
    logic        w_load_fast;
    logic [3:0]  w_nxt;
    logic        w_seterr;
    logic [2:0]  w_errc;

`ifdef SDC_BYTE_ADDR_EN
    assign w_arg = {r_lba[22:0], 9'b0};
`else
    assign w_arg = r_lba;
`endif

    assign w_rx8    = spi_dataRx[7:0];
    assign w_cnt_nx = r_cnt + 16'd1;
    assign w_xfer   = (r_state != c_IDLE) && (r_state != c_DONE);

    assign spi_start = w_xfer && (r_phase == c_P_ISSUE) && spi_rdy;
    assign wr_req    = spi_start && (r_state == c_WDATA);

    // Transmit word for the transfer about to be issued in the current state.
    always_comb begin
        w_load_tx   = 32'hFFFF_FFFF;
        w_load_fast = 1'b0;
        case (r_state)
            c_CMD: begin
                case (r_cnt[2:0])
                    3'd0:    w_load_tx = {24'hFFFFFF, (r_wr ? 8'h58 : 8'h51)};
                    3'd1:    w_load_tx = {24'hFFFFFF, w_arg[31:24]};
                    3'd2:    w_load_tx = {24'hFFFFFF, w_arg[23:16]};
                    3'd3:    w_load_tx = {24'hFFFFFF, w_arg[15:8]};
                    3'd4:    w_load_tx = {24'hFFFFFF, w_arg[7:0]};
                    default: w_load_tx = {24'hFFFFFF, 8'h01};
                endcase
            end
            c_WTOKEN: w_load_tx = {24'hFFFFFF, 8'hFE};
            c_RDATA:  w_load_fast = 1'b1;
            c_WDATA: begin
                w_load_tx   = wr_word;
                w_load_fast = 1'b1;
            end
            default: ;
        endcase
    end

    // Next state once the current transfer's receive data is available.
    always_comb begin
        w_nxt    = r_state;
        w_seterr = 1'b0;
        w_errc   = 3'd0;
        case (r_state)
            c_CMD: if (r_cnt == 16'd5) w_nxt = c_R1;
            c_R1: begin
                if (!w_rx8[7]) begin
                    if (w_rx8 == 8'h00) begin
                        w_nxt = r_wr ? c_WGAP : c_TOKEN;
                    end else begin
                        w_nxt = c_DESEL; w_seterr = 1'b1; w_errc = 3'd2;
                    end
                end else if (w_cnt_nx == c_RESP_LIM) begin
                    w_nxt = c_DESEL; w_seterr = 1'b1; w_errc = 3'd1;
                end
            end
            c_TOKEN: begin
                if (w_rx8 == 8'hFE) begin
                    w_nxt = c_RDATA;
                end else if (w_rx8 != 8'hFF) begin
                    w_nxt = c_DESEL; w_seterr = 1'b1; w_errc = 3'd4;
                end else if (w_cnt_nx == c_TOKEN_LIM) begin
                    w_nxt = c_DESEL; w_seterr = 1'b1; w_errc = 3'd3;
                end
            end
            c_RDATA:  if (r_wcnt == 7'd127) w_nxt = c_RCRC;
            c_RCRC:   if (r_cnt == 16'd1) w_nxt = c_DESEL;
            c_WGAP:   w_nxt = c_WTOKEN;
            c_WTOKEN: w_nxt = c_WDATA;
            c_WDATA:  if (r_wcnt == 7'd127) w_nxt = c_WCRC;
            c_WCRC:   if (r_cnt == 16'd1) w_nxt = c_WRESP;
            c_WRESP: begin
                if ((w_rx8 & 8'h1F) == 8'h05) begin
                    w_nxt = c_WBUSY;
                end else begin
                    w_nxt = c_DESEL; w_seterr = 1'b1; w_errc = 3'd5;
                end
            end
            c_WBUSY: begin
                if (w_rx8 != 8'h00) begin
                    w_nxt = c_DESEL;
                end else if (w_cnt_nx == c_TOKEN_LIM) begin
                    w_nxt = c_DESEL; w_seterr = 1'b1; w_errc = 3'd6;
                end
            end
            c_DESEL: w_nxt = c_DONE;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_phase    <= c_P_LOAD;
            r_cnt      <= 16'd0;
            r_wcnt     <= 7'd0;
            r_wr       <= 1'b0;
            r_lba      <= 32'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 3'd0;
            rd_word    <= 32'd0;
            rd_valid   <= 1'b0;
            ss_n       <= 1'b1;
            spi_fast   <= 1'b0;
            spi_dataTx <= 32'hFFFF_FFFF;
        end else begin
            done     <= 1'b0;
            rd_valid <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (go) begin
                        r_wr    <= wr;
                        r_lba   <= lba;
                        err     <= 3'd0;
                        busy    <= 1'b1;
                        ss_n    <= 1'b0;
                        r_state <= c_CMD;
                        r_phase <= c_P_LOAD;
                        r_cnt   <= 16'd0;
                        r_wcnt  <= 7'd0;
                    end
                end
                c_DONE: r_state <= c_IDLE;
                default: begin
                    case (r_phase)
                        c_P_LOAD: begin
                            spi_dataTx <= w_load_tx;
                            spi_fast   <= w_load_fast;
                            r_phase    <= c_P_ISSUE;
                        end
                        c_P_ISSUE:  if (spi_rdy) r_phase <= c_P_SETTLE;
                        c_P_SETTLE: r_phase <= c_P_WAIT;
                        default: begin
                            if (spi_rdy) begin
                                r_phase <= c_P_LOAD;
                                if (w_nxt != r_state) begin
                                    r_state <= w_nxt;
                                    r_cnt   <= 16'd0;
                                end else begin
                                    r_cnt   <= w_cnt_nx;
                                end
                                if (w_seterr) err <= w_errc;
                                if (w_nxt == c_DESEL) ss_n <= 1'b1;
                                if (w_nxt == c_DONE) begin
                                    done <= 1'b1;
                                    busy <= 1'b0;
                                end
                                if (r_state == c_RDATA) begin
                                    rd_word  <= spi_dataRx;
                                    rd_valid <= 1'b1;
                                end
                                if ((r_state == c_RDATA) || (r_state == c_WDATA))
                                    r_wcnt <= r_wcnt + 7'd1;
                            end
                        end
                    endcase
                end
            endcase
        end
    end

endmodule
`default_nettype wire
